// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point definitions for the CNN datapath: Q8.8 defaults,
// saturation limits and the neuron-stage state encoding.
package cnn_fixed_pkg;

    localparam int FXP_N = 16;
    localparam int FXP_Q = 8;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } neuron_state_e;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up, arithmetic shift by Q and saturation of a
// wide signed fixed-point value into a narrower signed result.
module fxp_round_sat #(
    parameter int IW = 40,
    parameter int OW = 16,
    parameter int Q  = 8
) (
    input  logic [IW-1:0] val_i,
    output logic [OW-1:0] res_o
);

    // One extra bit so adding the half-LSB can never wrap.
    localparam logic signed [IW:0] HALF = {{(IW-Q+1){1'b0}}, 1'b1, {(Q-1){1'b0}}};
    localparam logic signed [IW:0] MAXV = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] MINV = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    logic signed [IW:0] biased;
    logic signed [IW:0] shifted;

    always_comb begin
        biased  = $signed({val_i[IW-1], val_i}) + HALF;
        shifted = biased >>> Q;
        if (shifted > MAXV) begin
            res_o = MAXV[OW-1:0];
        end else if (shifted < MINV) begin
            res_o = MINV[OW-1:0];
        end else begin
            res_o = shifted[OW-1:0];
        end
    end

endmodule

// File: rtl/fc_mac_neuron.sv
// Fully-connected neuron: streams NUM_INPUTS Q8.8 activation/weight pairs,
// accumulates products plus bias at full precision, emits a rounded Q8.8 result.
//
// state | meaning
// IDLE  | waiting for start, bias captured on start
// ACCUM | accepting activation/weight beats, one registered product in flight
// DRAIN | folds the last product into acc and rounds/saturates the sum
// OUT   | result held on out_data until out_ready
module fc_mac_neuron
    import cnn_fixed_pkg::*;
#(
    parameter int N          = FXP_N,
    parameter int Q          = FXP_Q,
    parameter int NUM_INPUTS = 64,
    parameter int ACC_W      = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] bias,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [N-1:0] in_weight,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

    neuron_state_e        state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [2*N-1:0]       prod_q, prod_d;
    logic                 prod_valid_q, prod_valid_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [N-1:0]         out_data_q, out_data_d;

    logic                 beat;
    logic signed [2*N-1:0] mul;
    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W-1:0]     bias_ext;
    logic [ACC_W-1:0]     acc_next;
    logic [N-1:0]         rs_out;

    assign beat     = in_valid & in_ready_q;
    assign mul      = $signed(in_data) * $signed(in_weight);
    assign prod_ext = {{(ACC_W-2*N){prod_q[2*N-1]}}, prod_q};
    // Bias is Q8.8; shift into the Q16.16 product alignment.
    assign bias_ext = {{(ACC_W-N-Q){bias[N-1]}}, bias, {Q{1'b0}}};
    assign acc_next = acc_q + (prod_valid_q ? prod_ext : '0);

    fxp_round_sat #(
        .IW (ACC_W),
        .OW (N),
        .Q  (Q)
    ) u_round_sat (
        .val_i (acc_next),
        .res_o (rs_out)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        prod_d       = prod_q;
        prod_valid_d = prod_valid_q;
        count_d      = count_q;
        out_data_d   = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d        = bias_ext;
                    count_d      = '0;
                    prod_valid_d = 1'b0;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                if (beat) begin
                    prod_d       = mul;
                    prod_valid_d = 1'b1;
                    count_d      = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end else begin
                    prod_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                acc_d        = acc_next;
                prod_valid_d = 1'b0;
                out_data_d   = rs_out;
                state_d      = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fc_mac_neuron.sv
// Directed bench for fc_mac_neuron: a 4-input instance for sums, saturation,
// bubbles, backpressure and reset, and a 1-input instance for rounding.
module tb_fc_mac_neuron;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] bias = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0, in_weight = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [15:0] out_data_a, out_data_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_mac_neuron #(.N(16), .Q(8), .NUM_INPUTS(4), .ACC_W(40)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a)
    );

    fc_mac_neuron #(.N(16), .Q(8), .NUM_INPUTS(1), .ACC_W(40)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Runs one evaluation up to out_valid; leaves the result pending in OUT.
    task automatic run_neuron(input bit sel_b, input int n, input logic [15:0] b,
                              input logic [3:0][15:0] d, input logic [3:0][15:0] w,
                              input bit bubbles, output logic [15:0] res, output int lat);
        bit ov;
        @(negedge clk);
        bias = b;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 0;
        for (int i = 0; i < n; i++) begin
            if (bubbles && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
                lat++;
            end
            in_valid  = 1'b1;
            in_data   = d[i];
            in_weight = w[i];
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        ov = sel_b ? out_valid_b : out_valid_a;
        while (!ov && lat < 50) begin
            @(negedge clk);
            lat++;
            ov = sel_b ? out_valid_b : out_valid_a;
        end
        if (!ov) chk("out_valid_timeout", 32'(ov), 32'd1);
        res = sel_b ? out_data_b : out_data_a;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [3:0][15:0] d_basic, w_one, d_sat, w_sat_neg, d1, w1;
    logic [15:0] res, held;
    int lat;

    initial begin
        d_basic   = {16'h0040, 16'hFF00, 16'h0200, 16'h0100};
        w_one     = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        d_sat     = {16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
        w_sat_neg = {16'h8100, 16'h8100, 16'h8100, 16'h8100};

        #12;
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_data", 32'(out_data_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_neuron(1'b0, 4, 16'h0080, d_basic, w_one, 1'b0, res, lat);
        chk("basic_data", 32'(res), 32'h02C0);
        chk("basic_latency", 32'(lat), 32'd5);
        handshake();
        chk("basic_released", 32'(out_valid_a), 32'd0);

        run_neuron(1'b0, 4, 16'h0000, d_sat, d_sat, 1'b0, res, lat);
        chk("sat_pos", 32'(res), 32'h7FFF);
        handshake();
        run_neuron(1'b0, 4, 16'h0000, d_sat, w_sat_neg, 1'b0, res, lat);
        chk("sat_neg", 32'(res), 32'h8000);
        handshake();

        d1 = '0; w1 = '0;
        d1[0] = 16'h0001; w1[0] = 16'h0080;
        run_neuron(1'b1, 1, 16'h0000, d1, w1, 1'b0, res, lat);
        chk("round_half_pos", 32'(res), 32'h0001);
        chk("round_latency", 32'(lat), 32'd2);
        handshake();
        d1[0] = 16'hFFFF; w1[0] = 16'h0080;
        run_neuron(1'b1, 1, 16'h0000, d1, w1, 1'b0, res, lat);
        chk("round_half_neg", 32'(res), 32'h0000);
        handshake();
        d1[0] = 16'h0003; w1[0] = 16'h0040;
        run_neuron(1'b1, 1, 16'h0000, d1, w1, 1'b0, res, lat);
        chk("round_0p75", 32'(res), 32'h0001);
        handshake();

        run_neuron(1'b0, 4, 16'h0080, d_basic, w_one, 1'b1, res, lat);
        chk("bubble_data", 32'(res), 32'h02C0);
        chk("bubble_latency", 32'(lat), 32'd8);
        held = res;

        // Backpressure: result must hold and start/in_valid must be ignored.
        for (int i = 0; i < 10; i++) begin
            start_a  = (i % 3 == 0);
            bias     = 16'h1234;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid_a), 32'd1);
            chk("bp_out_data", 32'(out_data_a), 32'(held));
            chk("bp_in_ready", 32'(in_ready_a), 32'd0);
        end
        in_valid  = 1'b0;
        start_a   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start_a   = 1'b0;
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid_a), 32'd0);
        @(negedge clk);
        chk("hs_start_ignored", 32'(in_ready_a), 32'd0);

        // Abort after two beats, then rerun cleanly.
        bias = 16'h0080;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_data   = d_sat[i];
            in_weight = d_sat[i];
            @(negedge clk);
        end
        chk("pre_rst_in_ready", 32'(in_ready_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("async_rst_out_data", 32'(out_data_a), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_neuron(1'b0, 4, 16'h0080, d_basic, w_one, 1'b0, res, lat);
        chk("post_rst_data", 32'(res), 32'h02C0);
        chk("post_rst_latency", 32'(lat), 32'd5);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
